// File: rtl/instr_fetch.sv
// Fetch stage ahead of the dual-issue decoder: reads 64-bit instruction pairs from local
// store and queues them in a small FIFO, with branch-redirect flush and stale-read discard.
module instr_fetch #(
  parameter int LS_ADDR_WIDTH = 18,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     redirect,
  input  logic [LS_ADDR_WIDTH-1:0] redirect_pc,
  input  logic                     stall,
  output logic                     ls_req,
  output logic [LS_ADDR_WIDTH-1:0] ls_addr,
  input  logic                     ls_gnt,
  input  logic                     ls_rvalid,
  input  logic [63:0]              ls_rdata,
  output logic                     out_valid,
  output logic [31:0]              instr1,
  output logic [31:0]              instr2,
  output logic                     instr1_valid,
  output logic [LS_ADDR_WIDTH-1:0] pc_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t                   r_state;
  logic [LS_ADDR_WIDTH-1:0] r_fetchPc;
  logic                     r_kill;
  logic [PW-1:0]            r_wrPtr;
  logic [PW-1:0]            r_rdPtr;
  logic [CW-1:0]            r_count;

  logic [31:0]              r_memI1 [DEPTH];
  logic [31:0]              r_memI2 [DEPTH];
  logic [LS_ADDR_WIDTH-1:0] r_memPc [DEPTH];
  logic [DEPTH-1:0]         r_memV;

  logic                     w_outstanding;
  logic [CW-1:0]            w_inFlight;
  logic                     w_grant;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_readPending;
  logic [LS_ADDR_WIDTH-1:0] w_redirPc;
  logic                     w_unusedPcBits;

  assign w_outstanding = (r_state == WAIT) || (r_state == DISCARD);
  assign w_inFlight    = r_count + CW'(w_outstanding);
  assign ls_req        = (r_state == REQ) && (w_inFlight < CW'(DEPTH));
  assign ls_addr       = (r_state == REQ) ? r_fetchPc : '0;
  assign w_grant       = ls_req & ls_gnt;
  assign w_push        = (r_state == WAIT) & ls_rvalid & ~redirect;
  assign w_pop         = out_valid & ~stall;
  assign w_redirPc     = {redirect_pc[LS_ADDR_WIDTH-1:3], 3'b000};
  assign w_unusedPcBits = ^redirect_pc[1:0];

  // A read is still owed to us after this edge if we just got granted or are waiting without data
  assign w_readPending = (w_outstanding && !ls_rvalid) || w_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_fetchPc <= '0;
      r_kill    <= 1'b0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      r_count   <= '0;
    end else begin
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (redirect) begin
        r_count   <= '0;
        r_rdPtr   <= '0;
        r_wrPtr   <= '0;
        r_fetchPc <= w_redirPc;
        r_kill    <= redirect_pc[2];
        r_state   <= w_readPending ? DISCARD : REQ;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state   <= REQ;
              r_fetchPc <= '0;
            end
          end
          REQ: begin
            if (w_grant) r_state <= WAIT;
          end
          WAIT: begin
            if (ls_rvalid) begin
              r_kill    <= 1'b0;
              r_fetchPc <= r_fetchPc + LS_ADDR_WIDTH'(8);
              r_state   <= REQ;
            end
          end
          DISCARD: begin
            if (ls_rvalid) r_state <= REQ;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Killed slot 1 is stored as zero so the head can be presented without extra gating
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memI1[r_wrPtr] <= r_kill ? 32'h0 : ls_rdata[63:32];
      r_memI2[r_wrPtr] <= ls_rdata[31:0];
      r_memPc[r_wrPtr] <= r_fetchPc;
      r_memV[r_wrPtr]  <= ~r_kill;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(w_push && r_count == CW'(DEPTH)));
    end
  end

  assign out_valid    = (r_count != '0);
  assign instr1       = out_valid ? r_memI1[r_rdPtr] : '0;
  assign instr2       = out_valid ? r_memI2[r_rdPtr] : '0;
  assign pc_out       = out_valid ? r_memPc[r_rdPtr] : '0;
  assign instr1_valid = out_valid ? r_memV[r_rdPtr] : 1'b0;

endmodule
